// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin arbitration between req0/req1,
// 8N1 (or 8N2) framing, bit boundaries taken from rising edges of txc.
module uart_tx_arbiter #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       txc,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       grant,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);

  state_t     state, state_n;
  logic       txc_q;
  logic       armed;
  logic       tick;
  logic       winner;
  logic       rr, rr_n;
  logic       grant_n;
  logic       ack0_n, ack1_n;
  logic       tx_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [1:0] stop_cnt, stop_cnt_n;

  // Edge detector on txc; armed blocks a false tick in the first cycle after
  // reset when txc happens to be high already.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txc_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      txc_q <= txc;
      armed <= 1'b1;
    end
  end

  assign tick = txc & ~txc_q & armed;

  // rr holds the favoured requester when both ask at once.
  assign winner = (req0 & req1) ? rr : req1;

  assign busy = (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      grant    <= 1'b0;
      rr       <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      grant    <= grant_n;
      rr       <= rr_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
    end
  end

  // Next-state and next-datapath logic; every line change happens on a tick.
  always_comb begin
    state_n    = state;
    tx_n       = tx;
    ack0_n     = 1'b0;
    ack1_n     = 1'b0;
    grant_n    = grant;
    rr_n       = rr;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (req0 | req1) begin
          shreg_n = winner ? data1 : data0;
          grant_n = winner;
          ack0_n  = ~winner;
          ack1_n  = winner;
          rr_n    = ~winner;
          state_n = SYNC;
        end
      end
      SYNC: begin
        if (tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          tx_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            tx_n       = 1'b1;
            stop_cnt_n = 2'd1;
            state_n    = STOP;
          end else begin
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tx_n = 1'b1;
          if (stop_cnt == STOP_LAST) state_n = IDLE;
          else stop_cnt_n = stop_cnt + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of frames on a
// STOP_BITS=1 instance, plus hand sequences for 2 stop bits, a late request
// and a mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int unsigned HALF = 218;
  localparam int unsigned BIT  = 436;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       txc = 1'b0;

  logic       req0_a = 1'b0, req1_a = 1'b0;
  logic [7:0] data0_a = '0, data1_a = '0;
  logic       ack0_a, ack1_a, grant_a, busy_a, tx_a;

  logic       req0_b = 1'b0, req1_b = 1'b0;
  logic [7:0] data0_b = '0, data1_b = '0;
  logic       ack0_b, ack1_b, grant_b, busy_b, tx_b;

  int unsigned cyc = 0;
  int unsigned last_end = 0;
  int unsigned passed = 0;
  int unsigned total = 0;
  logic        both_seen = 1'b0;

  uart_tx_arbiter #(.STOP_BITS(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .txc(txc),
    .req0(req0_a), .req1(req1_a), .data0(data0_a), .data1(data1_a),
    .ack0(ack0_a), .ack1(ack1_a), .grant(grant_a), .busy(busy_a), .tx(tx_a)
  );

  uart_tx_arbiter #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .txc(txc),
    .req0(req0_b), .req1(req1_b), .data0(data0_b), .data1(data1_b),
    .ack0(ack0_b), .ack1(ack1_b), .grant(grant_b), .busy(busy_b), .tx(tx_b)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (HALF) @(negedge clk);
    txc = ~txc;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if ((ack0_a && ack1_a) || (ack0_b && ack1_b)) both_seen = 1'b1;

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic logic cur_tx(input int unsigned sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic cur_busy(input int unsigned sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [1:0] cur_ack(input int unsigned sel);
    return (sel == 0) ? {ack1_a, ack0_a} : {ack1_b, ack0_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ack(input int unsigned sel, output int unsigned n, output logic [1:0] mask);
    n = 0;
    mask = 2'b00;
    while (n < 6000) begin
      @(negedge clk);
      n++;
      mask = cur_ack(sel);
      if (mask != 2'b00) break;
    end
  endtask

  task automatic wait_start(input int unsigned sel, input int unsigned limit, output logic seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (cur_tx(sel) == 1'b0) seen = 1'b1;
    end
  endtask

  // Called at the first negedge where the start bit is visible; samples each
  // bit in the middle of its period and times the whole frame to busy low.
  task automatic frame_after_start(input int unsigned sel, input int unsigned stops,
                                   input logic [7:0] exp_byte, input string tag);
    int unsigned c0;
    int unsigned n;
    logic [7:0]  b;
    c0 = cyc;
    repeat (HALF) @(negedge clk);
    chk({tag, "_start"}, cur_tx(sel), 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = cur_tx(sel);
    end
    chk({tag, "_byte"}, b, exp_byte);
    for (int unsigned s = 0; s < stops; s++) begin
      repeat (BIT) @(negedge clk);
      chk({tag, "_stop"}, cur_tx(sel), 1'b1);
    end
    n = 0;
    while (cur_busy(sel) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"}, cyc - c0, BIT * (9 + stops));
    last_end = cyc;
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       eg;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int unsigned n;
    int unsigned c0;
    logic [1:0]  mask;
    logic        seen;
    logic        flag;
    string       tag;

    // Pending requesters keep the same data; grant order follows the
    // round-robin pointer starting at requester 0.
    vecs[0] = '{1'b1, 1'b1, 8'h55, 8'h0F, 1'b0, 8'h55};
    vecs[1] = '{1'b1, 1'b1, 8'h55, 8'h0F, 1'b1, 8'h0F};
    vecs[2] = '{1'b1, 1'b1, 8'h55, 8'h0F, 1'b0, 8'h55};
    vecs[3] = '{1'b1, 1'b1, 8'h55, 8'h0F, 1'b1, 8'h0F};
    vecs[4] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h55};
    vecs[5] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 8'h81};
    vecs[7] = '{1'b1, 1'b1, 8'h3C, 8'hE7, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'hE7, 1'b1, 8'hE7};

    repeat (5) @(negedge clk);
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ack", {ack1_a, ack0_a}, 2'b00);
    chk("rst_grant", grant_a, 1'b0);
    chk("rst_tx2", tx_b, 1'b1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("v%0d", i);
      req0_a = vecs[i].r0;
      req1_a = vecs[i].r1;
      if (vecs[i].r0) data0_a = vecs[i].d0;
      if (vecs[i].r1) data1_a = vecs[i].d1;
      wait_ack(0, n, mask);
      chk({tag, "_ack_lat"}, n, 1);
      chk({tag, "_ack_who"}, mask, vecs[i].eg ? 2'b10 : 2'b01);
      chk({tag, "_grant"}, grant_a, vecs[i].eg);
      if (mask[0]) req0_a = 1'b0;
      if (mask[1]) req1_a = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_pulse"}, cur_ack(0), 2'b00);
      chk({tag, "_busy"}, busy_a, 1'b1);
      wait_start(0, 1000, seen);
      chk({tag, "_start_seen"}, seen, 1'b1);
      if (i > 0) chk({tag, "_gap"}, cyc - last_end, BIT);
      frame_after_start(0, 1, vecs[i].eb, tag);
    end

    // Two stop bits, all-zero byte: 9 low periods then 2 high before idle.
    req0_b = 1'b1;
    data0_b = 8'h00;
    wait_ack(1, n, mask);
    chk("sb2_ack", mask, 2'b01);
    req0_b = 1'b0;
    wait_start(1, 1000, seen);
    chk("sb2_start_seen", seen, 1'b1);
    n = 0;
    while (tx_b == 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("sb2_low", n, 9 * BIT);
    n = 0;
    while (busy_b && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sb2_high", n, 2 * BIT);

    // Late request raised in the middle of the stop bit.
    req0_a = 1'b1;
    data0_a = 8'h3C;
    wait_ack(0, n, mask);
    chk("late_ack0", mask, 2'b01);
    req0_a = 1'b0;
    wait_start(0, 1000, seen);
    chk("late_start0_seen", seen, 1'b1);
    c0 = cyc;
    repeat (HALF + BIT * 9) @(negedge clk);
    req1_a = 1'b1;
    data1_a = 8'hE7;
    wait_ack(0, n, mask);
    chk("late_ack1_who", mask, 2'b10);
    chk("late_ack1_at", cyc - c0, 10 * BIT + 1);
    req1_a = 1'b0;
    wait_start(0, 1000, seen);
    chk("late_start1_at", cyc - c0, 11 * BIT);
    frame_after_start(0, 1, 8'hE7, "late");

    // Reset in the middle of data bit 3 of a requester-1 frame.
    req1_a = 1'b1;
    data1_a = 8'h0F;
    wait_ack(0, n, mask);
    chk("mid_ack", mask, 2'b10);
    req1_a = 1'b0;
    wait_start(0, 1000, seen);
    chk("mid_start_seen", seen, 1'b1);
    repeat (HALF + BIT * 4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1'b1);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_grant", grant_a, 1'b0);
    chk("mid_rst_ack", {ack1_a, ack0_a}, 2'b00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    flag = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (ack0_a || ack1_a || busy_a) flag = 1'b1;
    end
    chk("mid_no_reack", flag, 1'b0);
    req1_a = 1'b1;
    data1_a = 8'hC3;
    wait_ack(0, n, mask);
    chk("rst_ack_who", mask, 2'b10);
    chk("rst_grant1", grant_a, 1'b1);
    req1_a = 1'b0;
    wait_start(0, 1000, seen);
    chk("rst_start_seen", seen, 1'b1);
    frame_after_start(0, 1, 8'hC3, "rst");

    chk("ack_exclusive", both_seen, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter STOP_BITS, default 1, number of stop-bit periods per frame; legal values 1 or 2 only.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 txc  input  1  baud square wave from the baud-rate generator, synchronous to clk; a bit boundary ("tick") is a rising edge of txc.
REQ-005 req0 / req1  input  1 each  requester n has a byte to send; held high until ackn.
REQ-006 data0 / data1  input  8 each  byte of requester n; held stable while reqn is high.
REQ-007 ack0 / ack1  output  1 each  one-cycle pulse; byte of requester n accepted.
REQ-008 grant  output  1  index of the requester owning the current or last frame.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 tx  output  1  serial line, registered, idle high.

Function
REQ-011 Tick detection: txc registered into txc_q each clk; tick = txc & ~txc_q; exactly one tick per txc rising edge.
REQ-012 FSM states: IDLE, SYNC, START, DATA, STOP.
REQ-013 IDLE, no request: tx=1; no state change; ticks are ignored.
REQ-014 IDLE, at least one request at a clk edge: latch winner byte into the shift register, set grant to the winner, pulse ack of the winner high for the next cycle only, go to SYNC.
REQ-015 Arbitration with one request: that requester wins.
REQ-016 Arbitration with both requests: round-robin pointer selects the winner; the pointer moves to the other requester after every grant.
REQ-017 SYNC: wait for a tick; on the tick edge, tx<=0 and go to START.
REQ-018 START: on a tick, tx<=bit0 of the byte, bit counter<=0, go to DATA.
REQ-019 DATA: on each tick, transmit LSB first.
  - Counter < 7: tx<=next bit, counter+1.
  - Counter = 7: tx<=1, stop counter<=1, go to STOP.
REQ-020 STOP: on a tick, if stop counter = STOP_BITS go to IDLE, else increment the stop counter; tx stays 1.
REQ-021 Each line level is held exactly one txc period (tick to tick).
REQ-022 A request arriving after a frame starts has its ack delayed until IDLE.
  - First possible ack: the cycle after the final stop tick.
  - The next start bit cannot begin before the next tick, so stop-bit length is never shortened.
REQ-023 Request deassertion or data change during a frame has no effect on the frame in flight.
REQ-024 A tick in the same cycle a request is first seen in IDLE does not start the frame; the start bit waits for the next tick after SYNC is entered.
REQ-025 A tick and a request both present in the SYNC entry cycle: the tick is ignored.
REQ-026 ack0 and ack1 are never high together; at most one ack per frame.
REQ-027 Latency from acceptance (ack) to start bit: 1 to one full txc period plus 1 clk.

Reset
REQ-028 resetn low (asynchronous, including mid-frame) forces:
  - state=IDLE, tx=1, busy=0, ack0=ack1=0, grant=0
  - round-robin pointer favours requester 0
  - txc_q=0; shift register, bit and stop counters = 0
REQ-029 After resetn rises, the first tick is detected only on a genuine txc rising edge.
REQ-030 A frame interrupted by reset is discarded; its requester receives no second ack unless it re-requests.

Verification
REQ-031 Single frame: req0=1, data0=8'hA5, STOP_BITS=1, txc period 436 clk.
  - ack0 pulses one cycle after req0.
  - tx sequence tick-to-tick: 0,1,0,1,0,0,1,0,1,1.
  - busy falls at the stop-end tick.
REQ-032 Simultaneous requests after reset: req0=req1=1, data0=8'h55, data1=8'h0F.
  - Frame 1: grant=0, ack0, frame 8'h55.
  - Frame 2: grant=1, ack1, frame 8'h0F.
  - Line idles high at least one full bit between frames.
REQ-033 Round-robin fairness: req0 and req1 held high for four frames -> grant sequence 0,1,0,1; ack pulses alternate.
REQ-034 STOP_BITS=2, data0=8'h00 -> tx low for 9 bit periods (start + 8 data), then high for 2 periods before busy falls.
REQ-035 Reset mid-frame: resetn low during DATA bit 3.
  - Same cycle: tx=1, busy=0.
  - After release, req1=1 with data1=8'hC3 -> grant=1, complete correct frame.
REQ-036 Late request: req1 rises during STOP of a frame from requester 0 -> ack1 no earlier than the cycle after the final stop tick; start bit aligned to the following tick.
